frame_sequencer: RTL and testbench

//  Wishbone-configurable animation scheduler for the LED matrix frame buffer. CPU programs base,

---
 rtl/frame_sequencer_pkg.sv | 45 ++++
 rtl/frame_sequencer_if.sv | 21 ++
 rtl/frame_sequencer_regs.sv | 130 +++++++++++++
 rtl/frame_sequencer.sv | 177 +++++++++++++++++
 tb/tb_frame_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the frame sequencer: register word offsets, CTRL/STATUS bit
// positions, master FSM state encodings, the configuration bundle handed from the register
// file to the sequencer, and the DWELL normalisation helper.
package frame_sequencer_pkg;

    // Slave register word offsets (s_bus.adr[2:0])
    localparam logic [2:0] RegCtrl   = 3'd0;
    localparam logic [2:0] RegBase   = 3'd1;
    localparam logic [2:0] RegStride = 3'd2;
    localparam logic [2:0] RegDwell  = 3'd3;
    localparam logic [2:0] RegStatus = 3'd4;

    // CTRL bit positions
    localparam int unsigned CtrlEnBit   = 0;
    localparam int unsigned CtrlLoopBit = 1;
    localparam int unsigned CtrlNfLsb   = 8;

    // STATUS bit positions
    localparam int unsigned StatErrBit  = 31;
    localparam int unsigned StatDoneBit = 30;
    localparam int unsigned StatPendBit = 29;
    localparam int unsigned StatIdxLsb  = 16;

    // Master FSM state encodings
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLoad    = 3'd1;
    localparam logic [2:0] StWrite   = 3'd2;
    localparam logic [2:0] StWaitAck = 3'd3;
    localparam logic [2:0] StRun     = 3'd4;

    typedef struct packed {
        logic        en;
        logic        loop;
        logic [3:0]  nframes_m1;
        logic [14:0] base;
        logic [14:0] stride;
        logic [7:0]  dwell;
    } seq_cfg_t;

    // A programmed dwell of 0 behaves as 1 frame per step.
    function automatic logic [7:0] dwell_eff(input logic [7:0] dwell);
        return (dwell == 8'd0) ? 8'd1 : dwell;
    endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Classic Wishbone single-cycle bus bundle used for both the CPU-facing slave port and the
// matrix-facing master port.
//   adr, dat_w, we, sel, cyc, stb : driven by the bus master
//   dat_r, ack                    : driven by the bus slave
// The master modport omits dat_r: the sequencer only ever writes.
interface frame_sequencer_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic [DW-1:0] dat_r;
    logic          we;
    logic [3:0]    sel;
    logic          cyc;
    logic          stb;
    logic          ack;

    modport master (output adr, dat_w, we, sel, cyc, stb, input ack);
    modport slave  (input adr, dat_w, we, sel, cyc, stb, output dat_r, ack);
endinterface

// File: rtl/frame_sequencer_regs.sv
// Register file and Wishbone slave decode for the frame sequencer.
// Ports:
//   wb_clk_i, wb_reset_i   clock, asynchronous active-high reset
//   s_bus                  Wishbone slave (zero wait states, registered read data)
//   hw_clr_en_i            sequencer request to drop CTRL.EN (done or ack timeout)
//   hw_set_err_i           sequencer request to set STATUS.ERR
//   hw_set_done_i          sequencer request to set STATUS.DONE
//   pend_i, idx_i, addr_i  live sequencer state reflected in STATUS
//   cfg_o                  programmed configuration
module frame_sequencer_regs
    import frame_sequencer_pkg::*;
(
    input  logic             wb_clk_i,
    input  logic             wb_reset_i,
    frame_sequencer_if.slave s_bus,
    input  logic             hw_clr_en_i,
    input  logic             hw_set_err_i,
    input  logic             hw_set_done_i,
    input  logic             pend_i,
    input  logic [3:0]       idx_i,
    input  logic [14:0]      addr_i,
    output seq_cfg_t         cfg_o
);

    seq_cfg_t    cfg_q, cfg_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rmux;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [2:0]  word;
    logic        req;
    logic        wr;
    logic        unused_adr;

    assign word       = s_bus.adr[2:0];
    assign wdat       = s_bus.dat_w[31:0];
    assign sel        = s_bus.sel;
    assign unused_adr = ^s_bus.adr;

    // A new request is one not already being acknowledged, so each access acks exactly once.
    assign req = s_bus.cyc & s_bus.stb & ~ack_q;
    assign wr  = req & s_bus.we;

    always_comb begin
        rmux = '0;
        case (word)
            RegCtrl: begin
                rmux[CtrlEnBit]           = cfg_q.en;
                rmux[CtrlLoopBit]         = cfg_q.loop;
                rmux[CtrlNfLsb +: 4]      = cfg_q.nframes_m1;
            end
            RegBase:   rmux[14:0] = cfg_q.base;
            RegStride: rmux[14:0] = cfg_q.stride;
            RegDwell:  rmux[7:0]  = cfg_q.dwell;
            RegStatus: begin
                rmux[StatErrBit]          = err_q;
                rmux[StatDoneBit]         = done_q;
                rmux[StatPendBit]         = pend_i;
                rmux[StatIdxLsb +: 4]     = idx_i;
                rmux[14:0]                = addr_i;
            end
            default: rmux = '0;
        endcase
    end

    always_comb begin
        cfg_d   = cfg_q;
        err_d   = err_q;
        done_d  = done_q;
        ack_d   = req;
        rdata_d = (req && !s_bus.we) ? rmux : '0;

        if (wr) begin
            case (word)
                RegCtrl: begin
                    if (sel[0]) begin
                        cfg_d.en   = wdat[CtrlEnBit];
                        cfg_d.loop = wdat[CtrlLoopBit];
                    end
                    if (sel[1]) cfg_d.nframes_m1 = wdat[CtrlNfLsb +: 4];
                end
                RegBase: begin
                    if (sel[0]) cfg_d.base[7:0]  = wdat[7:0];
                    if (sel[1]) cfg_d.base[14:8] = wdat[14:8];
                end
                RegStride: begin
                    if (sel[0]) cfg_d.stride[7:0]  = wdat[7:0];
                    if (sel[1]) cfg_d.stride[14:8] = wdat[14:8];
                end
                RegDwell: begin
                    if (sel[0]) cfg_d.dwell = wdat[7:0];
                end
                RegStatus: begin
                    if (sel[3] && wdat[StatErrBit])  err_d  = 1'b0;
                    if (sel[3] && wdat[StatDoneBit]) done_d = 1'b0;
                end
                default: ;
            endcase
        end

        // Sequencer events override a coincident CPU write so a stop is never lost.
        if (hw_clr_en_i)   cfg_d.en = 1'b0;
        if (hw_set_err_i)  err_d    = 1'b1;
        if (hw_set_done_i) done_d   = 1'b1;
    end

    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            cfg_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            cfg_q   <= cfg_d;
            err_q   <= err_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign s_bus.ack   = ack_q;
    assign s_bus.dat_r = rdata_q;
    assign cfg_o       = cfg_q;

endmodule

// File: rtl/frame_sequencer.sv
// Wishbone-configurable animation scheduler for the LED matrix frame buffer. After the CPU
// enables it, every DWELL frame ticks the block writes the next frame address to the matrix
// control register over its own Wishbone master port.
// Ports:
//   wb_clk_i, wb_reset_i   clock, asynchronous active-high reset
//   s_bus                  CPU-facing Wishbone slave (configuration / status)
//   m_bus                  Wishbone master to the matrix frame-address register
//   frame_tick             single-cycle pulse at each matrix frame boundary
//   busy                   sequencer not idle
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int unsigned   AW          = 32,
    parameter int unsigned   DW          = 32,
    parameter logic [AW-1:0] MATRIX_ADR  = '0,
    parameter int unsigned   ACK_TIMEOUT = 64
) (
    input  logic              wb_clk_i,
    input  logic              wb_reset_i,
    frame_sequencer_if.slave  s_bus,
    frame_sequencer_if.master m_bus,
    input  logic              frame_tick,
    output logic              busy
);

    localparam int unsigned ToW = $clog2(ACK_TIMEOUT + 1);

    seq_cfg_t cfg;

    logic [2:0]    state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [14:0]   addr_q, addr_d;
    logic [7:0]    dwell_cnt_q, dwell_cnt_d;
    logic          pend_q, pend_d;
    logic          en_prev_q;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic          cyc_q, cyc_d;
    logic [DW-1:0] dat_q, dat_d;

    logic hw_clr_en;
    logic hw_set_err;
    logic hw_set_done;
    logic tick_live;
    logic advance;

    frame_sequencer_regs u_regs (
        .wb_clk_i      (wb_clk_i),
        .wb_reset_i    (wb_reset_i),
        .s_bus         (s_bus),
        .hw_clr_en_i   (hw_clr_en),
        .hw_set_err_i  (hw_set_err),
        .hw_set_done_i (hw_set_done),
        .pend_i        (pend_q),
        .idx_i         (idx_q),
        .addr_i        (addr_q),
        .cfg_o         (cfg)
    );

    // Frame ticks only pace playback while a sequence is active and enabled.
    assign tick_live = frame_tick && cfg.en &&
                       (state_q inside {StRun, StWrite, StWaitAck});

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        dwell_cnt_d = dwell_cnt_q;
        pend_d      = pend_q;
        to_cnt_d    = to_cnt_q;
        cyc_d       = cyc_q;
        dat_d       = dat_q;
        hw_clr_en   = 1'b0;
        hw_set_err  = 1'b0;
        hw_set_done = 1'b0;
        advance     = 1'b0;

        // >= rather than == so a DWELL lowered mid-count still advances promptly.
        if (tick_live) begin
            if (dwell_cnt_q >= dwell_eff(cfg.dwell) - 8'd1) begin
                dwell_cnt_d = 8'd0;
                advance     = 1'b1;
            end else begin
                dwell_cnt_d = dwell_cnt_q + 8'd1;
            end
        end

        case (state_q)
            StIdle: begin
                if (cfg.en && !en_prev_q) state_d = StLoad;
            end
            StLoad: begin
                idx_d       = 4'd0;
                addr_d      = cfg.base;
                dwell_cnt_d = 8'd0;
                pend_d      = 1'b1;
                state_d     = StWrite;
            end
            StWrite: begin
                cyc_d    = 1'b1;
                dat_d    = {{(DW - 16){1'b0}}, addr_q, 1'b0};
                pend_d   = 1'b0;
                to_cnt_d = '0;
                state_d  = StWaitAck;
            end
            StWaitAck: begin
                if (m_bus.ack) begin
                    cyc_d   = 1'b0;
                    state_d = StRun;
                end else if (to_cnt_q == ToW'(ACK_TIMEOUT - 1)) begin
                    cyc_d      = 1'b0;
                    hw_set_err = 1'b1;
                    hw_clr_en  = 1'b1;
                    state_d    = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!cfg.en)     state_d = StIdle;
                else if (pend_q) state_d = StWrite;
            end
            default: state_d = StIdle;
        endcase

        // Applied after the state logic so an advance landing on the WRITE cycle re-arms
        // PEND; repeated advances before the write simply overwrite ADDR (coalescing).
        if (advance) begin
            if (idx_q == cfg.nframes_m1) begin
                if (cfg.loop) begin
                    idx_d  = 4'd0;
                    addr_d = cfg.base;
                    pend_d = 1'b1;
                end else begin
                    hw_set_done = 1'b1;
                    hw_clr_en   = 1'b1;
                end
            end else begin
                idx_d  = idx_q + 4'd1;
                addr_d = addr_q + cfg.stride;
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            state_q     <= StIdle;
            idx_q       <= 4'd0;
            addr_q      <= 15'd0;
            dwell_cnt_q <= 8'd0;
            pend_q      <= 1'b0;
            en_prev_q   <= 1'b0;
            to_cnt_q    <= '0;
            cyc_q       <= 1'b0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            dwell_cnt_q <= dwell_cnt_d;
            pend_q      <= pend_d;
            en_prev_q   <= cfg.en;
            to_cnt_q    <= to_cnt_d;
            cyc_q       <= cyc_d;
            dat_q       <= dat_d;
        end
    end

    assign m_bus.adr   = MATRIX_ADR;
    assign m_bus.dat_w = dat_q;
    assign m_bus.we    = cyc_q;
    assign m_bus.sel   = {4{cyc_q}};
    assign m_bus.cyc   = cyc_q;
    assign m_bus.stb   = cyc_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: expected matrix writes are queued as stimulus is issued and a
// monitor pops/compares on each master handshake; register readbacks are compared directly.
module tb_frame_sequencer;
    import frame_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic frame_tick;
    logic busy;

    frame_sequencer_if #(.AW(32), .DW(32)) s_bus ();
    frame_sequencer_if #(.AW(32), .DW(32)) m_bus ();

    frame_sequencer #(
        .AW          (32),
        .DW          (32),
        .MATRIX_ADR  (32'h0),
        .ACK_TIMEOUT (64)
    ) dut (
        .wb_clk_i   (clk),
        .wb_reset_i (rst),
        .s_bus      (s_bus),
        .m_bus      (m_bus),
        .frame_tick (frame_tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int          ack_delay = 0;
    bit          ack_never = 1'b0;
    int          wait_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Matrix-side slave model: acks after ack_delay cycles of cyc, one-cycle ack pulse.
    initial begin
        m_bus.ack   = 1'b0;
        m_bus.dat_r = '0;
        forever begin
            @(posedge clk);
            #1;
            if (m_bus.ack) begin
                m_bus.ack = 1'b0;
            end else if (m_bus.cyc && m_bus.stb && !ack_never) begin
                if (wait_cnt >= ack_delay) begin
                    m_bus.ack = 1'b1;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: every completing master cycle must match the head of the expectation queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && m_bus.cyc && m_bus.stb && m_bus.ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %h want none", m_bus.dat_w);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("m_dat", m_bus.dat_w, mon_exp);
                    check("m_adr", m_bus.adr, 32'h0);
                    check("m_we_sel", 32'({m_bus.we, m_bus.sel}), 32'h1F);
                end
            end
        end
    end

    task automatic wb_access(input logic [2:0] a, input logic we, input logic [31:0] d,
                             input logic [3:0] sel, output logic [31:0] rd);
        int n;
        @(negedge clk);
        s_bus.adr   = {29'd0, a};
        s_bus.we    = we;
        s_bus.dat_w = d;
        s_bus.sel   = sel;
        s_bus.cyc   = 1'b1;
        s_bus.stb   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_bus.ack && n < 8);
        if (!s_bus.ack) begin
            checks++;
            errors++;
            $display("FAIL slave_ack: got no ack want ack within 8 cycles");
        end
        rd        = s_bus.dat_r;
        s_bus.cyc = 1'b0;
        s_bus.stb = 1'b0;
        s_bus.we  = 1'b0;
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] dummy;
        wb_access(a, 1'b1, d, sel, dummy);
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        wb_access(a, 1'b0, 32'h0, 4'hF, rd);
        check(name, rd, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_cyc(input string name);
        int n;
        n = 0;
        while (!m_bus.cyc && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(m_bus.cyc), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc_cycles;
        bit saw_cyc;

        rst         = 1'b1;
        frame_tick  = 1'b0;
        s_bus.adr   = '0;
        s_bus.dat_w = '0;
        s_bus.we    = 1'b0;
        s_bus.sel   = 4'h0;
        s_bus.cyc   = 1'b0;
        s_bus.stb   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_m_cyc", 32'({m_bus.cyc, m_bus.stb}), 32'd0);
        check("reset_m_dat", m_bus.dat_w, 32'h0);
        check("reset_s_ack", 32'(s_bus.ack), 32'd0);
        rst = 1'b0;
        read_check("reset_ctrl", RegCtrl, 32'h0);

        // Looping playback, DWELL=1, NFRAMES=4.
        wb_write(RegBase, 32'h100, 4'hF);
        wb_write(RegStride, 32'h80, 4'hF);
        wb_write(RegDwell, 32'h1, 4'hF);
        read_check("base_rb", RegBase, 32'h100);
        exp_q.push_back(32'h200);
        wb_write(RegCtrl, 32'h303, 4'hF);
        drain("loop_first", 30);
        exp_q.push_back(32'h300); tick(); drain("loop_w1", 20);
        exp_q.push_back(32'h400); tick(); drain("loop_w2", 20);
        exp_q.push_back(32'h500); tick(); drain("loop_w3", 20);
        exp_q.push_back(32'h200); tick(); drain("loop_wrap", 20);
        repeat (4) @(negedge clk);
        read_check("loop_status", RegStatus, 32'h0000_0100);
        wb_write(RegCtrl, 32'h0, 4'hF);
        wait_idle("loop_stop_idle");

        // DWELL=3: only ticks 3 and 6 advance.
        wb_write(RegDwell, 32'h3, 4'hF);
        exp_q.push_back(32'h200);
        wb_write(RegCtrl, 32'h703, 4'hF);
        drain("dwell_first", 30);
        tick(); tick();
        repeat (6) @(negedge clk);
        exp_q.push_back(32'h300); tick(); drain("dwell_t3", 20);
        tick(); tick();
        repeat (6) @(negedge clk);
        exp_q.push_back(32'h400); tick(); drain("dwell_t6", 20);
        repeat (4) @(negedge clk);
        read_check("dwell_status", RegStatus, 32'h0002_0200);
        wb_write(RegCtrl, 32'h0, 4'hF);
        wait_idle("dwell_stop_idle");

        // One-shot, NFRAMES=2: two writes then DONE.
        wb_write(RegDwell, 32'h1, 4'hF);
        exp_q.push_back(32'h200);
        wb_write(RegCtrl, 32'h101, 4'hF);
        drain("once_w0", 30);
        exp_q.push_back(32'h300); tick(); drain("once_w1", 20);
        tick();
        repeat (6) @(negedge clk);
        read_check("once_status_done", RegStatus, 32'h4001_0180);
        read_check("once_ctrl_en_clr", RegCtrl, 32'h100);
        check("once_busy", 32'(busy), 32'd0);
        wb_write(RegStatus, 32'h4000_0000, 4'hF);
        read_check("once_done_w1c", RegStatus, 32'h0001_0180);

        // Ack never arrives: 64 cycles of cyc, then ERR and stop.
        ack_never = 1'b1;
        wb_write(RegCtrl, 32'h101, 4'hF);
        wait_cyc("to_cyc_start");
        cyc_cycles = 0;
        while (m_bus.cyc && cyc_cycles < 200) begin
            cyc_cycles++;
            @(negedge clk);
        end
        check("to_cyc_len", 32'(cyc_cycles), 32'd64);
        saw_cyc = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (m_bus.cyc) saw_cyc = 1'b1;
        end
        check("to_no_retry", 32'(saw_cyc), 32'd0);
        check("to_busy", 32'(busy), 32'd0);
        read_check("to_status_err", RegStatus, 32'h8000_0100);
        read_check("to_ctrl_en_clr", RegCtrl, 32'h100);
        wb_write(RegStatus, 32'h8000_0000, 4'hF);
        read_check("to_err_w1c", RegStatus, 32'h0000_0100);
        ack_never = 1'b0;

        // Slow ack with three ticks inside the wait: one coalesced follow-up write.
        ack_delay = 10;
        exp_q.push_back(32'h200);
        wb_write(RegCtrl, 32'h703, 4'hF);
        wait_cyc("slow_cyc_start");
        tick(); tick(); tick();
        exp_q.push_back(32'h500);
        drain("slow_coalesce", 60);
        repeat (15) @(negedge clk);
        read_check("slow_status", RegStatus, 32'h0003_0280);
        wb_write(RegCtrl, 32'h0, 4'hF);
        wait_idle("slow_stop_idle");
        ack_delay = 0;

        // Byte-select honoured: only BASE[7:0] changes.
        wb_write(RegBase, 32'h0000_7FFF, 4'b0001);
        read_check("base_sel_byte0", RegBase, 32'h1FF);

        // Asynchronous reset in the middle of a master cycle.
        ack_never = 1'b1;
        wb_write(RegCtrl, 32'h101, 4'hF);
        wait_cyc("rst_cyc_start");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_cyc", 32'({m_bus.cyc, m_bus.stb}), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_dat", m_bus.dat_w, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ack_never = 1'b0;
        read_check("rst_ctrl", RegCtrl, 32'h0);
        read_check("rst_base", RegBase, 32'h0);
        read_check("rst_stride", RegStride, 32'h0);
        read_check("rst_dwell", RegDwell, 32'h0);
        read_check("rst_status", RegStatus, 32'h0);
        read_check("unmapped_rd", 3'd5, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
